// File: rtl/polar_reassemble.sv
// Polar-to-rectangular converter: r = abs*cos(ph), i = abs*sin(ph) from a quarter-wave
// sine table and one shared multiplier, sequenced by a five-state FSM.
module polar_reassemble #(
  parameter int QBITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [17:0] abs_in,
  input  logic [17:0] ph_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [17:0] r_out,
  output logic [17:0] i_out,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int TBL = (1 << QBITS) + 1;

  typedef enum logic [2:0] {IDLE, LOOK, MUL_R, MUL_I, DONE} state_t;

  state_t state_reg, state_next;

  // Table contents are evaluated at elaboration; the series is exact well past 17 bits.
  function automatic logic [16:0] sin_entry(input int k);
    real x, term, acc;
    x    = 1.5707963267948966 * real'(k) / real'(1 << QBITS);
    term = x;
    acc  = x;
    for (int n = 1; n < 12; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      acc  = acc + term;
    end
    return 17'($rtoi(acc * 65536.0 + 0.5));
  endfunction

  logic [16:0] sin_rom [TBL];

  genvar gi;
  generate
    for (gi = 0; gi < TBL; gi++) begin : g_rom
      assign sin_rom[gi] = sin_entry(gi);
    end
  endgenerate

  logic [16:0]      m_reg;
  logic [1:0]       q_reg;
  logic [QBITS-1:0] k_reg;
  logic [16:0]      cos_mag_reg, sin_mag_reg;
  logic             cos_neg_reg, sin_neg_reg;
  logic [17:0]      r_reg, i_reg;

  logic [QBITS:0] k_idx, kc_idx;
  logic [16:0]    t_k, t_kc;
  logic           unused_ph;

  assign k_idx     = {1'b0, k_reg};
  assign kc_idx    = (QBITS + 1)'(1 << QBITS) - k_idx;
  assign t_k       = sin_rom[k_idx];
  assign t_kc      = sin_rom[kc_idx];
  assign unused_ph = ^ph_in[15-QBITS:0];

  // Shared multiplier: cos operand in MUL_R, sin operand in MUL_I.
  logic [16:0] mul_b;
  logic        mul_neg;
  logic [33:0] prod;
  logic [34:0] prod_rnd;
  logic [16:0] mag_rnd;
  logic [17:0] res;

  assign mul_b    = (state_reg == MUL_I) ? sin_mag_reg : cos_mag_reg;
  assign mul_neg  = (state_reg == MUL_I) ? sin_neg_reg : cos_neg_reg;
  assign prod     = 34'(m_reg) * 34'(mul_b);
  assign prod_rnd = {1'b0, prod} + 35'd32768;
  assign mag_rnd  = 17'(prod_rnd >> 16);
  assign res      = mul_neg ? -{1'b0, mag_rnd} : {1'b0, mag_rnd};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = LOOK;
      end
      LOOK:  state_next = MUL_R;
      MUL_R: state_next = MUL_I;
      MUL_I: state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reg       <= '0;
      q_reg       <= '0;
      k_reg       <= '0;
      cos_mag_reg <= '0;
      sin_mag_reg <= '0;
      cos_neg_reg <= 1'b0;
      sin_neg_reg <= 1'b0;
      r_reg       <= '0;
      i_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            m_reg <= abs_in[17] ? 17'd0 : abs_in[16:0];
            q_reg <= ph_in[17:16];
            k_reg <= ph_in[15:16-QBITS];
          end
        end
        LOOK: begin
          // Odd quadrants swap the roles of k and its complement.
          cos_mag_reg <= q_reg[0] ? t_k  : t_kc;
          sin_mag_reg <= q_reg[0] ? t_kc : t_k;
          cos_neg_reg <= q_reg[1] ^ q_reg[0];
          sin_neg_reg <= q_reg[1];
        end
        MUL_R:   r_reg <= res;
        MUL_I:   i_reg <= res;
        default: ;
      endcase
    end
  end

  assign r_out = r_reg;
  assign i_out = i_reg;

endmodule

// File: tb/tb_polar_reassemble.sv
// Self-checking bench for polar_reassemble: vector table through a scoreboard queue,
// plus backpressure and mid-operation reset sequences.
module tb_polar_reassemble;

  logic        clk;
  logic        rst_n;
  logic [17:0] abs_in;
  logic [17:0] ph_in;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] r_out;
  logic [17:0] i_out;
  logic        out_valid;
  logic        out_ready;

  polar_reassemble dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .abs_in    (abs_in),
    .ph_in     (ph_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .r_out     (r_out),
    .i_out     (i_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [17:0]        abs_v;
    logic [17:0]        ph_v;
    logic signed [17:0] r_exp;
    logic signed [17:0] i_exp;
  } vec_t;

  localparam int NVEC = 12;
  localparam real PI = 3.14159265358979323846;

  vec_t        vecs [NVEC];
  logic [35:0] exp_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string name, input int idx, input longint act, input longint exp_v);
    n_tests++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp_v);
    end
  endtask

  function automatic longint qround(input real x);
    if (x < 0.0) return -longint'($rtoi($floor(-x + 0.5)));
    return longint'($rtoi($floor(x + 0.5)));
  endfunction

  function automatic longint scale(input longint m, input longint t);
    longint mag;
    mag = (m * (t < 0 ? -t : t) + 32768) >>> 16;
    return (t < 0) ? -mag : mag;
  endfunction

  // Reference: trig of the phase truncated to table resolution, rounded to Q16.
  task automatic model(input logic [17:0] a, input logic [17:0] p,
                       output logic signed [17:0] r, output logic signed [17:0] i);
    longint m, cv, sv;
    real    th;
    m  = a[17] ? 0 : longint'(a[16:0]);
    th = 2.0 * PI * real'({p[17:8], 8'h00}) / 262144.0;
    cv = qround(65536.0 * $cos(th));
    sv = qround(65536.0 * $sin(th));
    r  = 18'(scale(m, cv));
    i  = 18'(scale(m, sv));
  endtask

  task automatic run_vec(input int idx, input logic [17:0] a, input logic [17:0] p,
                         input logic signed [17:0] er, input logic signed [17:0] ei);
    int          n;
    logic [35:0] e;
    abs_in   = a;
    ph_in    = p;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      check("accept_timeout", idx, 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back({er, ei});
    #1;
    in_valid = 1'b0;
    abs_in   = 18'($urandom);
    ph_in    = 18'($urandom);
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1; n++;
    end
    check("latency", idx, n, 3);
    if (out_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("r_out", idx, $signed(r_out), $signed(e[35:18]));
      check("i_out", idx, $signed(i_out), $signed(e[17:0]));
    end else begin
      check("no_output", idx, 0, 1);
    end
    @(posedge clk); #1;
    check("valid_drop", idx, out_valid, 0);
    check("in_ready_back", idx, in_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int          n;
    int          seen;
    logic [35:0] e;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    abs_in    = '0;
    ph_in     = '0;
    out_ready = 1'b1;

    vecs[0] = '{18'd65536,  18'h00000, 18'sd65536,  18'sd0};
    vecs[1] = '{18'd65536,  18'h10000, 18'sd0,      18'sd65536};
    vecs[2] = '{18'd65536,  18'h20000, -18'sd65536, 18'sd0};
    vecs[3] = '{18'd65536,  18'h30000, 18'sd0,      -18'sd65536};
    vecs[4] = '{18'd65536,  18'h08000, 18'sd46341,  18'sd46341};
    vecs[5] = '{18'd131071, 18'h00000, 18'sd131071, 18'sd0};
    vecs[6] = '{18'h3FFD8,  18'h05555, 18'sd0,      18'sd0};
    vecs[7].abs_v  = 18'd1000;   vecs[7].ph_v  = 18'h04000;
    vecs[8].abs_v  = 18'd77777;  vecs[8].ph_v  = 18'h1A3C5;
    vecs[9].abs_v  = 18'd5;      vecs[9].ph_v  = 18'h2FFFF;
    vecs[10].abs_v = 18'd131071; vecs[10].ph_v = 18'h3F0FF;
    vecs[11].abs_v = 18'($urandom_range(0, 131071));
    vecs[11].ph_v  = 18'($urandom);
    for (int v = 7; v < NVEC; v++) model(vecs[v].abs_v, vecs[v].ph_v, vecs[v].r_exp, vecs[v].i_exp);

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 0, in_ready, 1);
    check("rst_out_valid", 0, out_valid, 0);
    check("rst_r_out", 0, r_out, 0);
    check("rst_i_out", 0, i_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < NVEC; v++) begin
      run_vec(v, vecs[v].abs_v, vecs[v].ph_v, vecs[v].r_exp, vecs[v].i_exp);
      $display("[TB] vec %0d abs=%0d ph=0x%05h -> r=%0d i=%0d", v, $signed(vecs[v].abs_v),
               vecs[v].ph_v, $signed(r_out), $signed(i_out));
    end

    // Backpressure: result held for 5 cycles while a second sample waits.
    out_ready = 1'b0;
    abs_in    = 18'd65536;
    ph_in     = 18'h10000;
    in_valid  = 1'b1;
    @(posedge clk);
    exp_q.push_back({18'sd0, 18'sd65536});
    #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1; n++;
    end
    check("bp_latency", 0, n, 3);
    e = exp_q[0];
    abs_in   = 18'd65536;
    ph_in    = 18'h08000;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_valid_held", c, out_valid, 1);
      check("bp_r_held", c, $signed(r_out), $signed(e[35:18]));
      check("bp_i_held", c, $signed(i_out), $signed(e[17:0]));
      check("bp_in_ready_low", c, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    void'(exp_q.pop_front());
    check("bp_valid_drop", 0, out_valid, 0);
    check("bp_in_ready_back", 0, in_ready, 1);
    @(posedge clk);
    exp_q.push_back({18'sd46341, 18'sd46341});
    #1;
    check("bp_queued_accepted", 0, in_ready, 0);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1; n++;
    end
    check("bp2_latency", 0, n, 3);
    e = exp_q.pop_front();
    check("bp2_r_out", 0, $signed(r_out), $signed(e[35:18]));
    check("bp2_i_out", 0, $signed(i_out), $signed(e[17:0]));
    $display("[TB] backpressure sample r=%0d i=%0d", $signed(r_out), $signed(i_out));
    @(posedge clk); #1;

    // Reset while the first product is being formed; that sample is discarded.
    abs_in   = 18'd65536;
    ph_in    = 18'h20000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_r_out", 0, r_out, 0);
    check("mid_rst_i_out", 0, i_out, 0);
    check("mid_rst_out_valid", 0, out_valid, 0);
    check("mid_rst_in_ready", 0, in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    check("mid_rst_no_valid", 0, seen, 0);
    run_vec(99, 18'd65536, 18'h00000, 18'sd65536, 18'sd0);
    $display("[TB] post-reset sample r=%0d i=%0d", $signed(r_out), $signed(i_out));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
